vram_linebuf: RTL and testbench

VRAM_LINEBUF -- requirements
Module: vram_linebuf

---
 rtl/vram_linebuf_if.sv | 30 +++
 rtl/vram_linebuf.sv | 147 ++++++++++++++
 tb/tb_vram_linebuf.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_linebuf_if.sv
// Bus between the timing generator / CPU side and the line-buffered VRAM.
// The master drives video timing and CPU write requests; the slave (the
// line buffer) returns the write handshake, the pixel and its status flags.
interface vram_linebuf_if #(
   parameter int HCNT_W = 10,
   parameter int VCNT_W = 10,
   parameter int PIX_W  = 1
);
   logic              visible;
   logic [HCNT_W-1:0] horicount;
   logic [VCNT_W-1:0] vertcount;
   logic              wr_valid;
   logic              wr_ready;
   logic [HCNT_W-1:0] wr_x;
   logic [VCNT_W-1:0] wr_y;
   logic [PIX_W-1:0]  wr_data;
   logic [PIX_W-1:0]  pixel;
   logic              fill_busy;
   logic              underrun;

   modport master (
      output visible, horicount, vertcount, wr_valid, wr_x, wr_y, wr_data,
      input  wr_ready, pixel, fill_busy, underrun
   );

   modport slave (
      input  visible, horicount, vertcount, wr_valid, wr_x, wr_y, wr_data,
      output wr_ready, pixel, fill_busy, underrun
   );
endinterface

// File: rtl/vram_linebuf.sv
// Framebuffer with double line buffering. While one line buffer feeds the
// DAC, the next row is copied from the framebuffer into the other one; the
// buffers swap at each line start. CPU writes go only to the framebuffer and
// are stalled while a fill owns the framebuffer port.
module vram_linebuf #(
   parameter int HRES   = 160,
   parameter int VRES   = 120,
   parameter int PIX_W  = 1,
   parameter int HCNT_W = 10,
   parameter int VCNT_W = 10
) (
   input logic           clk,
   input logic           rst_n,
   vram_linebuf_if.slave bus
);
   localparam int XW = $clog2(HRES);
   localparam int YW = $clog2(VRES);
   localparam int AW = $clog2(HRES * VRES);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   logic [PIX_W-1:0]  fb  [HRES*VRES];
   logic [PIX_W-1:0]  lb0 [HRES];
   logic [PIX_W-1:0]  lb1 [HRES];

   state_t            state_q;
   logic [HCNT_W-1:0] prevH_q;
   logic              active_q;
   logic              lbValid_q;
   logic              underrun_q;
   logic [PIX_W-1:0]  pixel_q;
   logic [XW-1:0]     fillCol_q;
   logic [YW-1:0]     fillRow_q;

   logic              lineStart;
   logic              swapNow;
   logic              pixSel;
   logic              pixOn;
   logic [XW-1:0]     pixX;
   logic [YW-1:0]     target_d;
   logic [PIX_W-1:0]  pixel_d;
   logic [AW-1:0]     fbAddr;
   logic [AW-1:0]     wrAddr;
   logic [PIX_W-1:0]  fbRd;
   logic              wrReady;
   logic              wrInRange;

   assign lineStart = (bus.horicount == '0) && (prevH_q != '0);
   assign wrReady   = rst_n && (state_q != FILL);
   assign wrInRange = (bus.wr_x < HCNT_W'(HRES)) && (bus.wr_y < VCNT_W'(VRES));
   assign fbAddr    = AW'(fillRow_q) * AW'(HRES) + AW'(fillCol_q);
   assign wrAddr    = AW'(bus.wr_y) * AW'(HRES) + AW'(bus.wr_x);
   assign fbRd      = fb[fbAddr];
   assign pixX      = bus.horicount[XW-1:0];

   // The pixel for column 0 is fetched on the same edge that swaps buffers,
   // so the read side looks ahead at the buffer that is about to be active.
   assign swapNow   = lineStart && (state_q == DONE);
   assign pixSel    = active_q ^ swapNow;
   assign pixOn     = lbValid_q | swapNow;

   assign bus.wr_ready  = wrReady;
   assign bus.fill_busy = (state_q == FILL);
   assign bus.underrun  = underrun_q;
   assign bus.pixel     = pixel_q;

   // Row to fetch for the next line, wrapping to row 0 after the last row.
   always_comb begin
      target_d = '0;
      if (bus.vertcount < VCNT_W'(VRES - 1)) begin
         target_d = YW'(bus.vertcount + 1'b1);
      end
   end

   // Select the displayed pixel from the active line buffer, blanking outside video.
   always_comb begin
      pixel_d = '0;
      if (bus.visible && pixOn && (bus.horicount < HCNT_W'(HRES))) begin
         pixel_d = pixSel ? lb1[pixX] : lb0[pixX];
      end
   end

   // Line-start detection, fill sequencing, buffer swapping and status flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         prevH_q    <= '0;
         active_q   <= 1'b0;
         lbValid_q  <= 1'b0;
         underrun_q <= 1'b0;
         pixel_q    <= '0;
         fillCol_q  <= '0;
         fillRow_q  <= '0;
      end else begin
         prevH_q <= bus.horicount;
         pixel_q <= pixel_d;
         case (state_q)
            IDLE: begin
               if (lineStart) begin
                  state_q   <= FILL;
                  fillCol_q <= '0;
                  fillRow_q <= target_d;
               end
            end
            FILL: begin
               if (lineStart) begin
                  underrun_q <= 1'b1;
                  fillCol_q  <= '0;
                  fillRow_q  <= target_d;
               end else if (fillCol_q == XW'(HRES - 1)) begin
                  state_q <= DONE;
               end else begin
                  fillCol_q <= fillCol_q + 1'b1;
               end
            end
            DONE: begin
               if (lineStart) begin
                  active_q  <= ~active_q;
                  lbValid_q <= 1'b1;
                  state_q   <= FILL;
                  fillCol_q <= '0;
                  fillRow_q <= target_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Framebuffer port: CPU writes only when no fill owns the port, out-of-range dropped.
   always_ff @(posedge clk) begin
      if (wrReady && bus.wr_valid && wrInRange) begin
         fb[wrAddr] <= bus.wr_data;
      end
   end

   // Copy one framebuffer word per fill cycle into the inactive line buffer.
   always_ff @(posedge clk) begin
      if (rst_n && (state_q == FILL) && !lineStart) begin
         if (active_q) begin
            lb0[fillCol_q] <= fbRd;
         end else begin
            lb1[fillCol_q] <= fbRd;
         end
      end
   end
endmodule

// File: tb/tb_vram_linebuf.sv
// Randomised bench for vram_linebuf. A row-level reference model (framebuffer
// array, fill snapshot taken at line start, displayed row swapped in when a
// fill had enough time) predicts every output cycle by cycle.
module tb_vram_linebuf;
   localparam int HRES = 160;
   localparam int VRES = 120;
   localparam int PW   = 1;

   logic clk = 1'b0;
   logic rst_n;

   vram_linebuf_if #(.HCNT_W(10), .VCNT_W(10), .PIX_W(PW)) bus ();

   vram_linebuf #(
      .HRES(HRES), .VRES(VRES), .PIX_W(PW), .HCNT_W(10), .VCNT_W(10)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   logic [PW-1:0] fbModel [VRES][HRES];
   logic [PW-1:0] snap    [HRES];
   logic [PW-1:0] shown   [HRES];
   bit   mFill, mValid, mUnder;
   int   mFillStart, mPrevH, cyc;

   int pixErr, busyErr, urErr, readyErr;
   int readyLow, writeTimeouts;
   bit hsDone;
   int checks, passes;

   logic [PW-1:0] linePix [1024];
   logic [PW-1:0] prevPix [1024];
   logic          urAt    [1024];
   logic          busyAt  [1024];
   int            busyCnt;

   // One clock: update the model from the inputs about to be sampled, then compare.
   task automatic tick();
      logic [PW-1:0] expPix;
      bit expReady, ls, expBusy, fired;
      int h, d, t;
      h = int'(bus.horicount);
      #1;
      expPix   = '0;
      expReady = 1'b0;
      if (!rst_n) begin
         mFill = 0; mValid = 0; mUnder = 0; mPrevH = 0;
      end else begin
         d = cyc - mFillStart;
         expReady = !(mFill && d >= 1 && d <= HRES);
         if (bus.wr_valid && expReady && bus.wr_x < HRES && bus.wr_y < VRES)
            fbModel[bus.wr_y][bus.wr_x] = bus.wr_data;
         ls = (h == 0) && (mPrevH != 0);
         if (ls) begin
            if (mFill) begin
               if (d > HRES) begin
                  for (int i = 0; i < HRES; i++) shown[i] = snap[i];
                  mValid = 1;
               end else begin
                  mUnder = 1;
               end
            end
            t = (int'(bus.vertcount) >= VRES - 1) ? 0 : int'(bus.vertcount) + 1;
            for (int i = 0; i < HRES; i++) snap[i] = fbModel[t][i];
            mFill = 1;
            mFillStart = cyc;
         end
         if (bus.visible && mValid && h < HRES) expPix = shown[h];
         mPrevH = h;
      end
      if (bus.wr_ready !== expReady) readyErr++;
      fired = bus.wr_valid && bus.wr_ready;
      if (bus.wr_valid) begin
         if (bus.wr_ready) hsDone = 1;
         else readyLow++;
      end
      expBusy = mFill && ((cyc - mFillStart) < HRES);
      @(posedge clk);
      #1;
      if (fired) bus.wr_valid = 1'b0;
      if (bus.pixel !== expPix) pixErr++;
      if (bus.fill_busy !== expBusy) busyErr++;
      if (bus.underrun !== mUnder) urErr++;
      cyc++;
   endtask

   // Drive one video line; optional reset cycle and optional held write request.
   task automatic runLine(input int vc, input int len, input int rstAt,
                          input int wrAt, input int wx, input int wy, input int wd);
      busyCnt = 0;
      for (int h = 0; h < len; h++) begin
         bus.horicount = 10'(h);
         bus.vertcount = 10'(vc);
         bus.visible   = (h < HRES) && (vc < VRES);
         rst_n         = (h != rstAt);
         if (h == wrAt) begin
            bus.wr_x     = 10'(wx);
            bus.wr_y     = 10'(wy);
            bus.wr_data  = PW'(wd);
            bus.wr_valid = 1'b1;
         end
         tick();
         linePix[h] = bus.pixel;
         urAt[h]    = bus.underrun;
         busyAt[h]  = bus.fill_busy;
         if (bus.fill_busy) busyCnt++;
      end
      rst_n = 1'b1;
      bus.wr_valid = 1'b0;
   endtask

   // CPU write with a bounded wait for the handshake.
   task automatic cpuWrite(input int x, input int y, input int d);
      bus.wr_x     = 10'(x);
      bus.wr_y     = 10'(y);
      bus.wr_data  = PW'(d);
      bus.wr_valid = 1'b1;
      hsDone = 0;
      for (int i = 0; i < 400 && !hsDone; i++) tick();
      if (!hsDone) writeTimeouts++;
      bus.wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.visible = 0; bus.horicount = '0; bus.vertcount = '0;
      bus.wr_valid = 0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;
      for (int i = 0; i < 3; i++) tick();
      #1;
      checks++;
      if (bus.wr_ready !== 1'b0) $display("[TB] FAIL reset_wr_ready: got %0b expected 0", bus.wr_ready);
      else passes++;
      checks++;
      if (bus.pixel !== '0) $display("[TB] FAIL reset_pixel: got %0h expected 0", bus.pixel);
      else passes++;
      checks++;
      if (bus.fill_busy !== 1'b0) $display("[TB] FAIL reset_fill_busy: got %0b expected 0", bus.fill_busy);
      else passes++;
      checks++;
      if (bus.underrun !== 1'b0) $display("[TB] FAIL reset_underrun: got %0b expected 0", bus.underrun);
      else passes++;
      rst_n = 1'b1;
   endtask

   task automatic test_preload();
      for (int y = 0; y < VRES; y++) begin
         for (int x = 0; x < HRES; x++) begin
            int d;
            d = int'($urandom_range(0, 1));
            if (y == 1) d = (x % 2 == 0) ? 1 : 0;
            if (y == 7 && x == 5) d = 0;
            cpuWrite(x, y, d);
         end
      end
      checks++;
      if (writeTimeouts !== 0) $display("[TB] FAIL preload_handshake: got %0d timeouts expected 0", writeTimeouts);
      else passes++;
   endtask

   task automatic test_fill();
      int bad;
      runLine(5, 200, -1, -1, 0, 0, 0);
      runLine(0, 800, -1, -1, 0, 0, 0);
      checks++;
      if (busyCnt !== HRES) $display("[TB] FAIL fill_busy_cycles: got %0d expected %0d", busyCnt, HRES);
      else passes++;
      runLine(1, 800, -1, -1, 0, 0, 0);
      bad = 0;
      for (int h = 0; h < HRES; h++) if (linePix[h] !== PW'(h % 2 == 0)) bad++;
      checks++;
      if (bad !== 0) $display("[TB] FAIL alt_pattern: got %0d bad pixels expected 0", bad);
      else passes++;
      checks++;
      if (linePix[HRES] !== '0) $display("[TB] FAIL blank_after_hres: got %0h expected 0", linePix[HRES]);
      else passes++;
      checks++;
      if (pixErr !== 0) $display("[TB] FAIL fill_model_pixels: got %0d errors expected 0", pixErr);
      else passes++;
   endtask

   task automatic test_wrap();
      int nz, bad;
      int vcs[4] = '{120, 121, 300, 524};
      runLine(118, 200, -1, -1, 0, 0, 0);
      runLine(119, 200, -1, -1, 0, 0, 0);
      nz = 0;
      for (int k = 0; k < 4; k++) begin
         runLine(vcs[k], 200, -1, -1, 0, 0, 0);
         for (int h = 0; h < 200; h++) if (linePix[h] !== '0) nz++;
      end
      checks++;
      if (nz !== 0) $display("[TB] FAIL blank_lines: got %0d nonzero pixels expected 0", nz);
      else passes++;
      runLine(0, 200, -1, -1, 0, 0, 0);
      bad = 0;
      for (int h = 0; h < HRES; h++) if (linePix[h] !== fbModel[0][h]) bad++;
      checks++;
      if (bad !== 0) $display("[TB] FAIL wrap_row0: got %0d bad pixels expected 0", bad);
      else passes++;
   endtask

   task automatic test_write_stall();
      readyLow = 0;
      hsDone = 0;
      runLine(6, 200, -1, 1, 5, 7, 1);
      checks++;
      if (readyLow !== HRES) $display("[TB] FAIL write_stall_cycles: got %0d expected %0d", readyLow, HRES);
      else passes++;
      checks++;
      if (hsDone !== 1'b1) $display("[TB] FAIL write_handshake: got %0b expected 1", hsDone);
      else passes++;
      runLine(7, 200, -1, -1, 0, 0, 0);
      checks++;
      if (linePix[5] !== '0) $display("[TB] FAIL write_not_early: got %0h expected 0", linePix[5]);
      else passes++;
      runLine(6, 200, -1, -1, 0, 0, 0);
      runLine(7, 200, -1, -1, 0, 0, 0);
      checks++;
      if (linePix[5] !== PW'(1)) $display("[TB] FAIL write_visible: got %0h expected 1", linePix[5]);
      else passes++;
   endtask

   task automatic test_out_of_range();
      logic [PW-1:0] keep40, keep02;
      keep40 = fbModel[4][0];
      keep02 = fbModel[0][2];
      cpuWrite(HRES, 3, int'(~keep40));
      checks++;
      if (hsDone !== 1'b1) $display("[TB] FAIL oob_x_handshake: got %0b expected 1", hsDone);
      else passes++;
      cpuWrite(2, VRES, int'(~keep02));
      checks++;
      if (hsDone !== 1'b1) $display("[TB] FAIL oob_y_handshake: got %0b expected 1", hsDone);
      else passes++;
      runLine(3, 200, -1, -1, 0, 0, 0);
      runLine(4, 200, -1, -1, 0, 0, 0);
      checks++;
      if (linePix[0] !== keep40) $display("[TB] FAIL oob_x_discard: got %0h expected %0h", linePix[0], keep40);
      else passes++;
      runLine(119, 200, -1, -1, 0, 0, 0);
      runLine(0, 200, -1, -1, 0, 0, 0);
      checks++;
      if (linePix[2] !== keep02) $display("[TB] FAIL oob_y_discard: got %0h expected %0h", linePix[2], keep02);
      else passes++;
   endtask

   task automatic test_underrun();
      int diff;
      runLine(10, 100, -1, -1, 0, 0, 0);
      checks++;
      if (urAt[99] !== 1'b0) $display("[TB] FAIL underrun_early: got %0b expected 0", urAt[99]);
      else passes++;
      for (int h = 0; h < 100; h++) prevPix[h] = linePix[h];
      runLine(11, 100, -1, -1, 0, 0, 0);
      checks++;
      if (urAt[0] !== 1'b1) $display("[TB] FAIL underrun_set: got %0b expected 1", urAt[0]);
      else passes++;
      diff = 0;
      for (int h = 0; h < 100; h++) if (linePix[h] !== prevPix[h]) diff++;
      checks++;
      if (diff !== 0) $display("[TB] FAIL underrun_keep_buffer: got %0d changed pixels expected 0", diff);
      else passes++;
      runLine(12, 200, -1, -1, 0, 0, 0);
      runLine(13, 200, -1, -1, 0, 0, 0);
      checks++;
      if (bus.underrun !== 1'b1) $display("[TB] FAIL underrun_sticky: got %0b expected 1", bus.underrun);
      else passes++;
   endtask

   task automatic test_reset_midfill();
      int nz, bad;
      runLine(20, 200, 81, -1, 0, 0, 0);
      checks++;
      if (busyAt[80] !== 1'b1) $display("[TB] FAIL midfill_busy_before: got %0b expected 1", busyAt[80]);
      else passes++;
      checks++;
      if (busyAt[81] !== 1'b0) $display("[TB] FAIL midfill_busy_after: got %0b expected 0", busyAt[81]);
      else passes++;
      checks++;
      if (linePix[81] !== '0) $display("[TB] FAIL midfill_pixel: got %0h expected 0", linePix[81]);
      else passes++;
      checks++;
      if (urAt[81] !== 1'b0) $display("[TB] FAIL midfill_underrun_clear: got %0b expected 0", urAt[81]);
      else passes++;
      runLine(21, 200, -1, -1, 0, 0, 0);
      nz = 0;
      for (int h = 0; h < 200; h++) if (linePix[h] !== '0) nz++;
      checks++;
      if (nz !== 0) $display("[TB] FAIL midfill_dark_line: got %0d nonzero pixels expected 0", nz);
      else passes++;
      runLine(22, 200, -1, -1, 0, 0, 0);
      bad = 0;
      for (int h = 0; h < HRES; h++) if (linePix[h] !== fbModel[22][h]) bad++;
      checks++;
      if (bad !== 0) $display("[TB] FAIL midfill_recover: got %0d bad pixels expected 0", bad);
      else passes++;
   endtask

   task automatic test_scoreboard();
      checks++;
      if (pixErr !== 0) $display("[TB] FAIL model_pixel: got %0d errors expected 0", pixErr);
      else passes++;
      checks++;
      if (busyErr !== 0) $display("[TB] FAIL model_fill_busy: got %0d errors expected 0", busyErr);
      else passes++;
      checks++;
      if (urErr !== 0) $display("[TB] FAIL model_underrun: got %0d errors expected 0", urErr);
      else passes++;
      checks++;
      if (readyErr !== 0) $display("[TB] FAIL model_wr_ready: got %0d errors expected 0", readyErr);
      else passes++;
   endtask

   // Scenario sequence.
   initial begin
      checks = 0; passes = 0; cyc = 0;
      pixErr = 0; busyErr = 0; urErr = 0; readyErr = 0;
      readyLow = 0; writeTimeouts = 0; hsDone = 0;
      mFill = 0; mValid = 0; mUnder = 0; mFillStart = 0; mPrevH = 0;
      for (int i = 0; i < HRES; i++) begin
         snap[i] = '0;
         shown[i] = '0;
      end
      test_reset();
      test_preload();
      test_fill();
      test_wrap();
      test_write_stall();
      test_out_of_range();
      test_underrun();
      test_reset_midfill();
      test_scoreboard();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
